// File: rtl/delay_counter.sv
// delay_counter: loadable, saturating down-counter with a zero-detect flag.
//
// A load strobe copies l into the counter; otherwise, while ce is high, the
// counter steps down by one per clock until it reaches zero and then stays
// there. thresh0 flags q == 0 with no extra register stage, so it changes in
// the same cycle as q.
//
// Reset asserts asynchronously (q clears at once) and is released through a
// two-flop synchronizer. The first counter update therefore happens on a
// clean clk edge, two edges after rst_n rises.
//
// Ports:
//   clk      input            rising-edge clock for all state
//   rst_n    input            asynchronous active-low reset
//   load     input            synchronous load strobe (priority over ce)
//   l        input  [WIDTH]   load value, sampled on edges where load=1
//   ce       input            count enable; tie to 1'b1 when free-running
//   q        output [WIDTH]   registered counter value
//   thresh0  output           high exactly when q == 0
module delay_counter #(
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] l,
  input  logic             ce,
  output logic [WIDTH-1:0] q,
  output logic             thresh0
);

  // Reset synchronizer: assertion goes straight through, release is shifted
  // in over two clk edges.
  logic [1:0] rst_sync_q;
  logic [1:0] rst_sync_d;
  logic       cnt_rst_n;

  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign cnt_rst_n = rst_sync_q[1];

  // Counter.
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = l;
    end else if (ce && !cnt_zero) begin
      // Zero is excluded above, so the decrement can never wrap.
      cnt_d = cnt_q - {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge cnt_rst_n) begin
    if (!cnt_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q       = cnt_q;
  assign thresh0 = cnt_zero;

endmodule

// File: tb/tb_delay_counter.sv
module tb_delay_counter;

  localparam int WIDTH = 48;

  logic             clk;
  logic             rst_n;
  logic             load;
  logic [WIDTH-1:0] l;
  logic             ce;
  logic [WIDTH-1:0] q;
  logic             thresh0;

  int checks = 0;
  int errors = 0;

  delay_counter #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .l       (l),
    .ce      (ce),
    .q       (q),
    .thresh0 (thresh0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [WIDTH-1:0] exp_q,
                       input logic exp_t);
    checks++;
    assert (q === exp_q) else begin
      errors++;
      $error("FAIL %s q: observed %0h expected %0h", tag, q, exp_q);
    end
    checks++;
    assert (thresh0 === exp_t) else begin
      errors++;
      $error("FAIL %s thresh0: observed %b expected %b", tag, thresh0, exp_t);
    end
    $display("step %s q=%0h thresh0=%b", tag, q, thresh0);
  endtask

  initial begin
    logic [WIDTH-1:0] all_ones;
    all_ones = '1;

    // Reset held with l=10, load=0.
    rst_n = 1'b0;
    load  = 1'b0;
    l     = 48'd10;
    ce    = 1'b1;
    #2;
    check("reset_async_start", 48'd0, 1'b1);
    tick();
    tick();
    check("reset_held", 48'd0, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("reset_release_hold", 48'd0, 1'b1);
    end

    // Basic count from 15.
    load = 1'b1;
    l    = 48'd15;
    tick();
    load = 1'b0;
    check("basic_load", 48'd15, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      tick();
      check("basic_count", 48'(15 - k), (k == 15));
    end
    tick();
    check("basic_saturate", 48'd0, 1'b1);

    // Enable gating: load 5, freeze 3 cycles at 3.
    load = 1'b1;
    l    = 48'd5;
    tick();
    load = 1'b0;
    check("gate_load", 48'd5, 1'b0);
    tick();
    check("gate_count", 48'd4, 1'b0);
    tick();
    check("gate_count", 48'd3, 1'b0);
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("gate_frozen", 48'd3, 1'b0);
    end
    ce = 1'b1;
    tick();
    check("gate_resume", 48'd2, 1'b0);
    tick();
    check("gate_resume", 48'd1, 1'b0);
    tick();
    check("gate_zero", 48'd0, 1'b1);

    // Reload mid-count.
    load = 1'b1;
    l    = 48'd15;
    tick();
    load = 1'b0;
    check("reload_first", 48'd15, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("reload_pre", 48'(15 - k), 1'b0);
    end
    load = 1'b1;
    l    = 48'd3;
    tick();
    load = 1'b0;
    check("reload_new", 48'd3, 1'b0);
    tick();
    check("reload_count", 48'd2, 1'b0);
    tick();
    check("reload_count", 48'd1, 1'b0);
    tick();
    check("reload_zero", 48'd0, 1'b1);

    // Load has priority over ce=0.
    ce   = 1'b0;
    load = 1'b1;
    l    = 48'd9;
    tick();
    load = 1'b0;
    ce   = 1'b1;
    check("load_over_ce", 48'd9, 1'b0);

    // Load of 0 mid-count.
    load = 1'b1;
    l    = 48'd0;
    tick();
    load = 1'b0;
    check("load_zero", 48'd0, 1'b1);

    // All-ones load counts down without wrapping.
    load = 1'b1;
    l    = all_ones;
    tick();
    load = 1'b0;
    check("max_load", 48'hFFFF_FFFF_FFFF, 1'b0);
    tick();
    check("max_dec1", 48'hFFFF_FFFF_FFFE, 1'b0);
    tick();
    check("max_dec2", 48'hFFFF_FFFF_FFFD, 1'b0);

    // Hold at zero with ce=1.
    load = 1'b1;
    l    = 48'd0;
    tick();
    load = 1'b0;
    tick();
    check("zero_hold_ce", 48'd0, 1'b1);

    // Asynchronous reset between edges while q=7.
    load = 1'b1;
    l    = 48'd7;
    tick();
    load = 1'b0;
    check("async_pre", 48'd7, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", 48'd0, 1'b1);
    load = 1'b1;
    l    = 48'd20;
    tick();
    check("reset_ignores_load", 48'd0, 1'b1);
    load  = 1'b0;
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("post_reset_idle", 48'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
